period_meter: RTL
=================

# period_meter

Measures the period and high time of a slow, asynchronous square wave in units of `refclk` cycles. It sits on the receiving end of a divided-clock path, for example checking the output of the clock divider or an external tick, and presents the result to status logic or the seven-segment display. The block reports a one-cycle `valid` pulse per measured period. If the input stops toggling, it flags a timeout.

## Interface
- `W`, default 32: width of the counter and result registers.
- `TIMEOUT`, default 100000000: number of cycles without a rising edge before timeout. Legal range is 2 ≤ TIMEOUT < 2^W.

Ports:
- `refclk`  in  1: the only clock. All logic runs on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sig_in`  in  1: asynchronous square wave under measurement.
- `period`  out  W: cycles between the last two rising edges.
- `high_time`  out  W: cycles `sig_in` stayed high within that period.
- `valid`  out  1: one-cycle pulse when `period` and `high_time` update.
- `locked`  out  1: at least one full period has been measured since the last reset or timeout.
- `timeout`  out  1: sticky flag meaning no rising edge arrived within TIMEOUT cycles.

## Operation
- Input conditioning:
  - Synchronizer chain `s0 <= sig_in; s1 <= s0; s2 <= s1`.
  - `rise = s1 & ~s2`; `fall = ~s1 & s2`.
- Counter `cnt` (W bits):
  - Cleared to 0 on `rise`.
  - Otherwise `cnt + 1`.
  - Never exceeds TIMEOUT−1.
- States:
  - IDLE: no reference edge yet.
  - MEAS: a reference rise has been seen.
- IDLE transitions:
  - On `rise`: go to MEAS, clear `cnt`, clear `hpend`, set `seen_fall` to 0.
  - No `valid` is produced in IDLE.
- MEAS, on `fall`: `hpend <= cnt + 1`, `seen_fall <= 1`.
- MEAS, on `rise`:
  - `period <= cnt + 1`.
  - `high_time <= seen_fall ? hpend : cnt + 1`.
  - `valid <= 1`, `locked <= 1`, `timeout <= 0`.
  - `cnt <= 0`, `seen_fall <= 0`.
- MEAS, when `cnt == TIMEOUT−1` with no `rise`:
  - Go to IDLE.
  - `timeout <= 1`, `locked <= 0`.
  - `period` and `high_time` hold their last values.
- Timeout in IDLE: the same TIMEOUT check applies, so a dead input sets `timeout` even before the first edge.
- Clearing `timeout`: it stays set until the next `rise` in MEAS or until `reset`.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins.
- `rise` and `fall` can never be asserted in the same cycle.
- All arithmetic is unsigned W-bit. Since TIMEOUT < 2^W, nothing wraps.

## Timing
- Reset values:
  - Outputs: `period=0`, `high_time=0`, `valid=0`, `locked=0`, `timeout=0`.
  - Internal: state=IDLE, `cnt=0`, `s0`/`s1`/`s2`=0, `hpend=0`, `seen_fall=0`.
- Reset applied mid-measurement discards the partial count. The next rise after reset is treated as the reference edge.
- Edge latency: if `sig_in` rises before edge k, `rise` is asserted in the cycle after edge k+1, and `valid`/`period` are registered at edge k+2. Latency is therefore 3 edges from the input transition.
- `valid` is high for exactly one cycle per measured period.
- `period`/`high_time` are stable between `valid` pulses.
- Minimum measurable period is 2 cycles. Pulses shorter than 1 cycle may be missed; this is allowed.

## Structure
- Shared package `meter_pkg`: holds the state enum (IDLE, MEAS).
- Sub-module `sync_edge`:
  - Contains the 3-flop synchronizer plus `rise`/`fall` detection.
  - Ports `refclk`, `reset`, `d`, `rise`, `fall`.
  - Reusable for the button and switch inputs.
- Top-level content: state register, counter, result registers.

## Test plan
- Basic period: square wave with period 4, high 2, driven as a divided `refclk` with N=4. Required: first `valid` only after the second rise, `period=4`, `high_time=2`, `locked=1`, then `valid` every 4 cycles.
- Asymmetric wave: high 3 cycles, low 7 cycles. Required: `period=10`, `high_time=3` on every `valid`.
- Timeout: TIMEOUT=16, toggle for three periods of 8, then hold `sig_in` low. Required: exactly 16 cycles after the last `rise`, `timeout=1`, `locked=0`, `period` stays 8, no further `valid`.
- Recovery after timeout: resume the wave of period 6. Required:
  - The first rise gives no `valid` and `timeout` stays 1.
  - The second rise gives `valid` with `period=6` and clears `timeout`.
- Reset mid-period: assert `reset` for 1 cycle between two rises. Required:
  - All outputs are 0 the cycle after.
  - No `valid` on the next rise.
  - A correct `valid` on the rise after that.
- Edge-vs-timeout collision: TIMEOUT=8 with a rise arriving so that `rise` coincides with `cnt==7`. Required: `valid` with `period=8`, `timeout` stays 0.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared definitions for the period meter.
//   meter_state_t : measurement state
//     IDLE - no reference rising edge has been seen yet
//     MEAS - a reference rising edge has been seen; the next rise closes a period
package meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } meter_state_t;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer with rising/falling edge detection for a slow
// asynchronous input. Reusable for buttons, switches and tick inputs.
// Ports:
//   refclk : clock
//   reset  : synchronous, active-high reset
//   d      : asynchronous input
//   rise   : one-cycle strobe, synchronized input went 0 -> 1
//   fall   : one-cycle strobe, synchronized input went 1 -> 0
module sync_edge (
  input  logic refclk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  // sync_reg[0] is the metastability catcher; edges are detected between
  // stages 1 and 2 so that only settled values feed the detector.
  logic [2:0] sync_reg;

  always_ff @(posedge refclk) begin
    if (reset) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], d};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];
  assign fall = ~sync_reg[1] & sync_reg[2];

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in
// refclk cycles, and flags a timeout when the input stops toggling.
// Parameters:
//   W       : counter/result width
//   TIMEOUT : cycles without a rise before timeout (2 <= TIMEOUT < 2^W)
// Ports:
//   refclk    : clock
//   reset     : synchronous, active-high reset
//   sig_in    : asynchronous input under measurement
//   period    : cycles between the last two rising edges
//   high_time : cycles sig_in was high within that period
//   valid     : one-cycle pulse when period/high_time update
//   locked    : a full period has been measured since reset/timeout
//   timeout   : sticky, no rise within TIMEOUT cycles
module period_meter
  import meter_pkg::*;
#(
  parameter int              W       = 32,
  parameter longint unsigned TIMEOUT = 100000000
) (
  input  logic         refclk,
  input  logic         reset,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic rise;
  logic fall;

  sync_edge u_sync_edge (
    .refclk (refclk),
    .reset  (reset),
    .d      (sig_in),
    .rise   (rise),
    .fall   (fall)
  );

  meter_state_t state_reg;
  meter_state_t state_next;

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic [W-1:0] cnt_plus1;
  logic [W-1:0] hpend_reg;
  logic         seen_fall_reg;
  logic [W-1:0] period_reg;
  logic [W-1:0] high_time_reg;
  logic         valid_reg;
  logic         locked_reg;
  logic         timeout_reg;

  logic cnt_at_last;
  logic arm_hit;      // reference rise while idle
  logic meas_hit;     // rise closing a measured period
  logic fall_hit;     // fall inside a measurement
  logic timeout_hit;  // counter expired without a rise (rise has priority)

  assign cnt_at_last = (cnt_reg == CNT_LAST);
  assign cnt_plus1   = cnt_reg + W'(1);

  // ---------------- state register ----------------
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    if (rise) begin
      state_next = MEAS;
    end else if (cnt_at_last) begin
      state_next = IDLE;
    end
  end

  // ---------------- output/strobe decode ----------------
  always_comb begin
    arm_hit     = 1'b0;
    meas_hit    = 1'b0;
    fall_hit    = 1'b0;
    timeout_hit = 1'b0;
    if (rise) begin
      if (state_reg == MEAS) begin
        meas_hit = 1'b1;
      end else begin
        arm_hit = 1'b1;
      end
    end else begin
      if (fall && (state_reg == MEAS)) begin
        fall_hit = 1'b1;
      end
      timeout_hit = cnt_at_last;
    end
  end

  // The counter saturates at CNT_LAST once expired; the timeout condition
  // then simply re-asserts each cycle, which is harmless because the flags
  // it sets are already set.
  always_comb begin
    cnt_next = cnt_plus1;
    if (rise) begin
      cnt_next = '0;
    end else if (cnt_at_last) begin
      cnt_next = cnt_reg;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge refclk) begin
    if (reset) begin
      cnt_reg       <= '0;
      hpend_reg     <= '0;
      seen_fall_reg <= 1'b0;
      period_reg    <= '0;
      high_time_reg <= '0;
      valid_reg     <= 1'b0;
      locked_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      valid_reg <= meas_hit;

      if (arm_hit) begin
        hpend_reg     <= '0;
        seen_fall_reg <= 1'b0;
      end else if (meas_hit) begin
        seen_fall_reg <= 1'b0;
      end else if (fall_hit) begin
        hpend_reg     <= cnt_plus1;
        seen_fall_reg <= 1'b1;
      end

      if (meas_hit) begin
        period_reg    <= cnt_plus1;
        // No fall seen means the input stayed high for the whole period.
        high_time_reg <= seen_fall_reg ? hpend_reg : cnt_plus1;
        locked_reg    <= 1'b1;
        timeout_reg   <= 1'b0;
      end else if (timeout_hit) begin
        locked_reg  <= 1'b0;
        timeout_reg <= 1'b1;
      end
    end
  end

  assign period    = period_reg;
  assign high_time = high_time_reg;
  assign valid     = valid_reg;
  assign locked    = locked_reg;
  assign timeout   = timeout_reg;

endmodule
